div_ctrl: RTL

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 41 ++++
 rtl/div_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_pkg
//  Description : Shared state encodings, handshake constants and helpers for
//                the multi-cycle 32-bit restoring divider controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

  // Divider controller states
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Result handshake levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Start request levels
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Number of restoring steps for a 32-bit quotient
  localparam logic [5:0] DIV_STEPS = 6'd32;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Two's-complement negation
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage : div_ctrl_pkg
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl
//  Description : Multi-cycle signed/unsigned 32-bit divider. One restoring
//                step per clock, 33 clocks from accepted start to ready.
//                result_o = {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [33:0] trial;
  logic        trial_ok;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Trial subtraction on the shifted partial remainder; bit 33 is the borrow
  assign trial    = {1'b0, rem_q, dvd_q[31]} - {2'b00, dvs_q};
  assign trial_ok = ~trial[33];

  // Sign correction applied when the result is registered
  assign quo_fix = qneg_q ? neg32(dvd_q) : dvd_q;
  assign rem_fix = rneg_q ? neg32(rem_q) : rem_q;

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if ((start_i == DIV_START) && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d = DIV_ON;
            cnt_d   = 6'd0;
            rem_d   = '0;
            if (signed_div_i) begin
              dvd_d  = abs32(opdata1_i);
              dvs_d  = abs32(opdata2_i);
              qneg_d = opdata1_i[31] ^ opdata2_i[31];
              rneg_d = opdata1_i[31];
            end else begin
              dvd_d  = opdata1_i;
              dvs_d  = opdata2_i;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end
          end
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          cnt_d    = 6'd0;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q == DIV_STEPS) begin
          state_d  = DIV_END;
          cnt_d    = 6'd0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
        end else begin
          rem_d = trial_ok ? trial[31:0] : {rem_q[30:0], dvd_q[31]};
          dvd_d = {dvd_q[30:0], trial_ok};
          cnt_d = cnt_q + 6'd1;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        cnt_d    = 6'd0;
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= 6'd0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule : div_ctrl
`default_nettype wire
